exe_stage_core: RTL and testbench

Execute-stage core of the 5-stage ARM pipeline. Consumes Val1, the Val2 operand produced by the shift/immediate operand generator, and the decoded control bits. Performs the ALU operation, maintains the NZCV status register, and computes the branch target. Drives the registered EXE/MEM pipeline outputs with freeze and flush support.

---
 rtl/exe_stage_core.sv | 133 +++++++++++++
 tb/tb_exe_stage_core.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/exe_stage_core.sv
// Execute stage of the 5-stage ARM pipeline: ALU, NZCV status register, branch target and EXE/MEM
// register. Define EXE_FWD_EN to enable the operand forwarding muxes on val1/val_rm.
module exe_stage_core (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        flush,
    input  logic [3:0]  exe_cmd,
    input  logic        s_in,
    input  logic        wb_en,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic        b_in,
    input  logic [3:0]  dest,
    input  logic [31:0] pc,
    input  logic [31:0] val1,
    input  logic [31:0] val_rm,
    input  logic [31:0] val2,
    input  logic [23:0] imm24,
    input  logic [1:0]  sel_src1,
    input  logic [1:0]  sel_src2,
    input  logic [31:0] fwd_mem,
    input  logic [31:0] fwd_wb,
    output logic [3:0]  status,
    output logic        branch_taken,
    output logic [31:0] branch_addr,
    output logic [31:0] alu_res_q,
    output logic [31:0] val_rm_q,
    output logic [3:0]  dest_q,
    output logic        wb_en_q,
    output logic        mem_r_en_q,
    output logic        mem_w_en_q
);

    logic [31:0] op_a;
    logic [31:0] rm_val;

`ifdef EXE_FWD_EN
    always_comb begin
        case (sel_src1)
            2'b01:   op_a = fwd_mem;
            2'b10:   op_a = fwd_wb;
            default: op_a = val1;
        endcase
        case (sel_src2)
            2'b01:   rm_val = fwd_mem;
            2'b10:   rm_val = fwd_wb;
            default: rm_val = val_rm;
        endcase
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{sel_src1, sel_src2, fwd_mem, fwd_wb};
    assign op_a       = val1;
    assign rm_val     = val_rm;
`endif

    logic [3:0]  status_q;
    logic [3:0]  nzcv_d;
    logic [31:0] alu_res_d;
    logic [32:0] arith;
    logic        carry_in;

    assign carry_in = status_q[1];

    always_comb begin
        alu_res_d = '0;
        arith     = '0;
        nzcv_d    = status_q;
        unique case (exe_cmd)
            4'b0001: alu_res_d = val2;
            4'b1001: alu_res_d = ~val2;
            4'b0110: alu_res_d = op_a & val2;
            4'b0111: alu_res_d = op_a | val2;
            4'b1000: alu_res_d = op_a ^ val2;
            4'b0010, 4'b0011: begin
                arith     = {1'b0, op_a} + {1'b0, val2} + {32'b0, (exe_cmd[0] & carry_in)};
                alu_res_d = arith[31:0];
                nzcv_d[1] = arith[32];
                nzcv_d[0] = (op_a[31] == val2[31]) && (alu_res_d[31] != op_a[31]);
            end
            4'b0100, 4'b0101: begin
                // SBC borrows when C is clear; carry out of a subtract means "no borrow"
                arith     = {1'b0, op_a} - {1'b0, val2} - {32'b0, (exe_cmd[0] & ~carry_in)};
                alu_res_d = arith[31:0];
                nzcv_d[1] = ~arith[32];
                nzcv_d[0] = (op_a[31] != val2[31]) && (alu_res_d[31] != op_a[31]);
            end
            default: alu_res_d = '0;
        endcase
        if (exe_cmd inside {4'b0001, 4'b1001, 4'b0010, 4'b0011, 4'b0100, 4'b0101,
                            4'b0110, 4'b0111, 4'b1000}) begin
            nzcv_d[3] = alu_res_d[31];
            nzcv_d[2] = (alu_res_d == 32'b0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= '0;
            alu_res_q  <= '0;
            val_rm_q   <= '0;
            dest_q     <= '0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            mem_w_en_q <= 1'b0;
        end else begin
            if (flush) begin
                alu_res_q  <= '0;
                val_rm_q   <= '0;
                dest_q     <= '0;
                wb_en_q    <= 1'b0;
                mem_r_en_q <= 1'b0;
                mem_w_en_q <= 1'b0;
            end else if (!freeze) begin
                alu_res_q  <= alu_res_d;
                val_rm_q   <= rm_val;
                dest_q     <= dest;
                wb_en_q    <= wb_en;
                mem_r_en_q <= mem_r_en;
                mem_w_en_q <= mem_w_en;
            end
            if (s_in && !freeze && !flush) begin
                status_q <= nzcv_d;
            end
        end
    end

    assign status       = status_q;
    assign branch_taken = b_in & ~flush;
    assign branch_addr  = pc + {{6{imm24[23]}}, imm24, 2'b00};

endmodule

// File: tb/tb_exe_stage_core.sv
// Directed self-checking bench for exe_stage_core: ALU ops and flags, freeze/flush, branch,
// forwarding (build-dependent) and reset.
module tb_exe_stage_core;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, s_in, wb_en, mem_r_en, mem_w_en, b_in;
    logic [3:0]  exe_cmd, dest;
    logic [31:0] pc, val1, val_rm, val2, fwd_mem, fwd_wb;
    logic [23:0] imm24;
    logic [1:0]  sel_src1, sel_src2;
    logic [3:0]  status, dest_q;
    logic        branch_taken, wb_en_q, mem_r_en_q, mem_w_en_q;
    logic [31:0] branch_addr, alu_res_q, val_rm_q;

    int checks = 0;
    int failures = 0;

    exe_stage_core dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .flush        (flush),
        .exe_cmd      (exe_cmd),
        .s_in         (s_in),
        .wb_en        (wb_en),
        .mem_r_en     (mem_r_en),
        .mem_w_en     (mem_w_en),
        .b_in         (b_in),
        .dest         (dest),
        .pc           (pc),
        .val1         (val1),
        .val_rm       (val_rm),
        .val2         (val2),
        .imm24        (imm24),
        .sel_src1     (sel_src1),
        .sel_src2     (sel_src2),
        .fwd_mem      (fwd_mem),
        .fwd_wb       (fwd_wb),
        .status       (status),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .alu_res_q    (alu_res_q),
        .val_rm_q     (val_rm_q),
        .dest_q       (dest_q),
        .wb_en_q      (wb_en_q),
        .mem_r_en_q   (mem_r_en_q),
        .mem_w_en_q   (mem_w_en_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic [3:0] cmd, input logic s, input logic [31:0] a,
                      input logic [31:0] b);
        exe_cmd = cmd;
        s_in    = s;
        val1    = a;
        val2    = b;
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; s_in = 1'b0; wb_en = 1'b1;
        mem_r_en = 1'b1; mem_w_en = 1'b1; b_in = 1'b0; exe_cmd = 4'b0010; dest = 4'hF;
        pc = '0; val1 = 32'h1234; val_rm = 32'h55; val2 = 32'h1; imm24 = '0;
        sel_src1 = 2'b00; sel_src2 = 2'b00; fwd_mem = '0; fwd_wb = '0;
        step();
        check("rst_alu", alu_res_q, 32'h0);
        check("rst_status", {28'b0, status}, 32'h0);
        check("rst_ctrl", {29'b0, wb_en_q, mem_r_en_q, mem_w_en_q}, 32'h0);
        check("rst_dest", {28'b0, dest_q}, 32'h0);

        // ADDS overflow into sign bit
        rst = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b1; dest = 4'd3; val_rm = 32'hAA;
        op(4'b0010, 1'b1, 32'h7FFF_FFFF, 32'h1);
        step();
        check("adds_res", alu_res_q, 32'h8000_0000);
        check("adds_nzcv", {28'b0, status}, 32'h9);
        check("adds_ctrl", {28'b0, wb_en_q, mem_r_en_q, mem_w_en_q, 1'b0}, 32'ha);
        check("adds_dest", {28'b0, dest_q}, 32'h3);
        check("adds_rm", val_rm_q, 32'hAA);

        // CMP 5,5
        wb_en = 1'b0; mem_w_en = 1'b0;
        op(4'b0100, 1'b1, 32'd5, 32'd5);
        step();
        check("cmp_nzcv", {28'b0, status}, 32'h6);
        check("cmp_wb", {31'b0, wb_en_q}, 32'h0);

        // SUBS 3-5 leaves C=0, then SBC 10-3-1
        wb_en = 1'b1;
        op(4'b0100, 1'b1, 32'd3, 32'd5);
        step();
        check("subs_res", alu_res_q, 32'hFFFF_FFFE);
        check("subs_nzcv", {28'b0, status}, 32'h8);
        op(4'b0101, 1'b1, 32'd10, 32'd3);
        step();
        check("sbc_res", alu_res_q, 32'd6);
        check("sbc_nzcv", {28'b0, status}, 32'h2);

        // ADDS sets C, back-to-back ADC consumes it
        op(4'b0010, 1'b1, 32'hFFFF_FFFF, 32'h1);
        step();
        check("adds_c_res", alu_res_q, 32'h0);
        check("adds_c_nzcv", {28'b0, status}, 32'h6);
        op(4'b0011, 1'b0, 32'd1, 32'd2);
        step();
        check("adc_res", alu_res_q, 32'd4);
        check("adc_nzcv_hold", {28'b0, status}, 32'h6);

        // Logic ops: only N/Z move
        op(4'b1000, 1'b1, 32'h0000_F0F0, 32'h0000_FF00);
        step();
        check("eor_res", alu_res_q, 32'h0000_0FF0);
        check("eor_nzcv", {28'b0, status}, 32'h2);
        op(4'b1001, 1'b1, 32'h0, 32'h0);
        step();
        check("mvn_res", alu_res_q, 32'hFFFF_FFFF);
        check("mvn_nzcv", {28'b0, status}, 32'hA);
        op(4'b0110, 1'b1, 32'hF0, 32'h0F);
        step();
        check("tst_nzcv", {28'b0, status}, 32'h6);
        op(4'b0111, 1'b0, 32'hF0, 32'h0F);
        step();
        check("orr_res", alu_res_q, 32'hFF);
        op(4'b0001, 1'b0, 32'h0, 32'hCAFE);
        step();
        check("mov_res", alu_res_q, 32'hCAFE);
        op(4'b1111, 1'b1, 32'h9, 32'h9);
        step();
        check("undef_res", alu_res_q, 32'h0);
        check("undef_nzcv", {28'b0, status}, 32'h6);

        // Freeze holds everything
        dest = 4'd5; wb_en = 1'b1;
        op(4'b0010, 1'b0, 32'd1, 32'd1);
        step();
        check("pre_frz_res", alu_res_q, 32'd2);
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dest = 4'(i + 8);
            op(4'b0100, 1'b1, 32'(i), 32'd100);
            step();
            check("frz_res", alu_res_q, 32'd2);
            check("frz_dest", {28'b0, dest_q}, 32'h5);
            check("frz_nzcv", {28'b0, status}, 32'h6);
        end
        flush = 1'b1; mem_r_en = 1'b1; mem_w_en = 1'b1;
        step();
        check("flush_ctrl", {29'b0, wb_en_q, mem_r_en_q, mem_w_en_q}, 32'h0);
        check("flush_dest", {28'b0, dest_q}, 32'h0);
        check("flush_res", alu_res_q, 32'h0);
        check("flush_nzcv", {28'b0, status}, 32'h6);

        // Branch target, combinational and independent of freeze
        flush = 1'b0; mem_r_en = 1'b0; mem_w_en = 1'b0;
        pc = 32'h100; imm24 = 24'hFF_FFFE; b_in = 1'b1;
        #1;
        check("br_taken", {31'b0, branch_taken}, 32'h1);
        check("br_addr", branch_addr, 32'hF8);
        imm24 = 24'h00_0010;
        #1;
        check("br_addr_fwd", branch_addr, 32'h140);
        flush = 1'b1;
        #1;
        check("br_flushed", {31'b0, branch_taken}, 32'h0);
        flush = 1'b0; b_in = 1'b0;

        // Forwarding muxes
        freeze = 1'b0;
        fwd_mem = 32'h20; fwd_wb = 32'h77; val_rm = 32'h11;
        sel_src1 = 2'b01; sel_src2 = 2'b10;
        op(4'b0010, 1'b0, 32'd1, 32'd4);
        step();
`ifdef EXE_FWD_EN
        check("fwd_a", alu_res_q, 32'h24);
        check("fwd_rm", val_rm_q, 32'h77);
`else
        check("fwd_a", alu_res_q, 32'h5);
        check("fwd_rm", val_rm_q, 32'h11);
`endif
        sel_src1 = 2'b11; sel_src2 = 2'b11;
        step();
        check("sel11_a", alu_res_q, 32'h5);
        check("sel11_rm", val_rm_q, 32'h11);
        sel_src1 = 2'b00; sel_src2 = 2'b00;

        // Reset mid-stream with a status update pending
        mem_r_en = 1'b1; dest = 4'd7;
        op(4'b0010, 1'b1, 32'h8000_0000, 32'h8000_0000);
        rst = 1'b1;
        step();
        check("mid_rst_res", alu_res_q, 32'h0);
        check("mid_rst_nzcv", {28'b0, status}, 32'h0);
        check("mid_rst_ctrl", {29'b0, wb_en_q, mem_r_en_q, mem_w_en_q}, 32'h0);
        check("mid_rst_dest", {28'b0, dest_q}, 32'h0);
        check("mid_rst_rm", val_rm_q, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
